// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out: free-running counters, half-resolution x/y for the drawer,
// and sync/blank/colour delay-aligned to the drawer's pixel_data. VGA_TEST_PATTERN_EN adds colour bars.
module vga_scanout #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter int unsigned PIXEL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pixel_data,
  input  logic        test_mode,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {PH_START, PH_RUN} phase_e;

  phase_e phase_q, phase_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic       fs_q, fs_d;
  logic [PIXEL_LATENCY-1:0] de_pipe_q, de_pipe_d;
  logic [PIXEL_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIXEL_LATENCY-1:0] vs_pipe_q, vs_pipe_d;
  logic       de_out_q, de_out_d, hs_out_q, hs_out_d, vs_out_q, vs_out_d;
  logic [15:0] rgb_q, rgb_d;
  logic [15:0] src;
  logic       running, active_raw, hs_raw, vs_raw;

`ifdef VGA_TEST_PATTERN_EN
  logic [3*PIXEL_LATENCY-1:0] bar_pipe_q, bar_pipe_d;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // The first clock after reset holds (0,0) so that frame_start can be a registered
  // pulse aligned with x/y; raw timing is masked in that clock.
  always_comb begin
    running  = (phase_q == PH_RUN);
    phase_d  = PH_RUN;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    if (running) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
    x_d  = hcnt_d[9:1];
    y_d  = vcnt_d[9:1];
    fs_d = (hcnt_d == '0) && (vcnt_d == '0);

    active_raw = running && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_raw     = !(running && (hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_raw     = !(running && (vcnt_q >= VS_BEG) && (vcnt_q < VS_END));

    de_pipe_d = PIXEL_LATENCY'({de_pipe_q, active_raw});
    hs_pipe_d = PIXEL_LATENCY'({hs_pipe_q, hs_raw});
    vs_pipe_d = PIXEL_LATENCY'({vs_pipe_q, vs_raw});

    src = pixel_data;
`ifdef VGA_TEST_PATTERN_EN
    bar_pipe_d = (3 * PIXEL_LATENCY)'({bar_pipe_q, hcnt_q[9:7]});
    if (test_mode) begin
      unique case (bar_pipe_q[3*PIXEL_LATENCY-1 -: 3])
        3'd0: src = 16'hFFFF;
        3'd1: src = 16'hFFE0;
        3'd2: src = 16'h07FF;
        3'd3: src = 16'h07E0;
        3'd4: src = 16'hF81F;
        3'd5: src = 16'hF800;
        3'd6: src = 16'h001F;
        3'd7: src = 16'h0000;
      endcase
    end
`endif

    de_out_d = de_pipe_q[PIXEL_LATENCY-1];
    hs_out_d = hs_pipe_q[PIXEL_LATENCY-1];
    vs_out_d = vs_pipe_q[PIXEL_LATENCY-1];
    rgb_d    = de_pipe_q[PIXEL_LATENCY-1] ? src : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_START;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      de_pipe_q <= '0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      de_out_q  <= 1'b0;
      hs_out_q  <= 1'b1;
      vs_out_q  <= 1'b1;
      rgb_q     <= '0;
`ifdef VGA_TEST_PATTERN_EN
      bar_pipe_q <= '0;
`endif
    end else begin
      phase_q   <= phase_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      de_pipe_q <= de_pipe_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      de_out_q  <= de_out_d;
      hs_out_q  <= hs_out_d;
      vs_out_q  <= vs_out_d;
      rgb_q     <= rgb_d;
`ifdef VGA_TEST_PATTERN_EN
      bar_pipe_q <= bar_pipe_d;
`endif
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign vga_hs      = hs_out_q;
  assign vga_vs      = vs_out_q;
  assign vga_de      = de_out_q;
  assign vga_r       = rgb_q[15:11];
  assign vga_g       = rgb_q[10:5];
  assign vga_b       = rgb_q[4:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: three instances (PIXEL_LATENCY 1, 2, 4) with full horizontal
// timing and a shortened vertical frame, checked every clock against a time-based model.
module tb_vga_scanout;

  localparam int HT  = 800;
  localparam int VA  = 8;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic test_mode = 1'b0;
  logic [15:0] pd1 = '0, pd2 = '0, pd4 = '0;
  logic [8:0] x1, y1, x2, y2, x4, y4;
  logic fs1, hs1, vs1, de1, fs2, hs2, vs2, de2, fs4, hs4, vs4, de4;
  logic [4:0] r1, b1, r2, b2, r4, b4;
  logic [5:0] g1, g2, g4;

  int t = -1;
  bit running = 1'b0;
  bit in_rst = 1'b0;
  bit first_run = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int de_cnt = 0, vs_cnt = 0, hs_cnt = 0, last_fs = 0;

  always #5 clk = ~clk;

  vga_scanout #(.V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .PIXEL_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .pixel_data(pd1), .test_mode(test_mode), .x(x1), .y(y1),
    .frame_start(fs1), .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1), .vga_r(r1), .vga_g(g1), .vga_b(b1));
  vga_scanout #(.V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .PIXEL_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .pixel_data(pd2), .test_mode(test_mode), .x(x2), .y(y2),
    .frame_start(fs2), .vga_hs(hs2), .vga_vs(vs2), .vga_de(de2), .vga_r(r2), .vga_g(g2), .vga_b(b2));
  vga_scanout #(.V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .PIXEL_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .pixel_data(pd4), .test_mode(test_mode), .x(x4), .y(y4),
    .frame_start(fs4), .vga_hs(hs4), .vga_vs(vs4), .vga_de(de4), .vga_r(r4), .vga_g(g4), .vga_b(b4));

  function automatic int hpos(input int ts);
    return (ts < 0) ? 0 : ts % HT;
  endfunction

  function automatic int vpos(input int ts);
    return (ts < 0) ? 0 : (ts / HT) % VT;
  endfunction

  // Drawer stand-in: colour encodes the scan coordinate it belongs to.
  function automatic logic [15:0] pat(input int ts);
    logic [8:0] xv, yv;
    if (ts < 0) return 16'h0000;
    xv = 9'(hpos(ts) / 2);
    yv = 9'(vpos(ts) / 2);
    return {xv[4:0], yv[5:0], xv[4:0]};
  endfunction

  function automatic bit const_win(input int ts);
    return (ts >= FT) && (ts < 2 * FT);
  endfunction

  function automatic bit tm(input int ts);
    return (ts >= 2 * FT) && (ts < 3 * FT);
  endfunction

  function automatic logic [15:0] pd_for(input int ts, input int lat);
    return const_win(ts) ? 16'hF800 : pat(ts - lat);
  endfunction

  function automatic logic [15:0] bar(input int idx);
    case (idx)
      0: return 16'hFFFF;  1: return 16'hFFE0;  2: return 16'h07FF;  3: return 16'h07E0;
      4: return 16'hF81F;  5: return 16'hF800;  6: return 16'h001F;  default: return 16'h0000;
    endcase
  endfunction

  // Expected {x, y, frame_start, hs, vs, de, rgb} at time ts for a given latency.
  function automatic logic [37:0] model(input int ts, input int lat);
    int d, hd, vd;
    logic fs, hs, vs, de;
    logic [15:0] src, rgb;
    fs = (ts >= 0) && (ts % FT == 0);
    d  = ts - lat - 1;
    if (d < 0) begin
      de = 1'b0; hs = 1'b1; vs = 1'b1; rgb = '0;
    end else begin
      hd  = hpos(d);
      vd  = vpos(d);
      de  = (hd < 640) && (vd < VA);
      hs  = !((hd >= 656) && (hd < 752));
      vs  = !((vd >= VA + VFP) && (vd < VA + VFP + VSW));
      src = (TP && tm(ts - 1)) ? bar(hd / 128) : pd_for(ts - 1, lat);
      rgb = de ? src : 16'h0000;
    end
    return {9'(hpos(ts) / 2), 9'(vpos(ts) / 2), fs, hs, vs, de, rgb};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  task automatic drive();
    pd1 = pd_for(t, 1);
    pd2 = pd_for(t, 2);
    pd4 = pd_for(t, 4);
    test_mode = tm(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    running = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_rst = 1'b1;
    end
    rst = 1'b0;
    in_rst = 1'b0;
    t = -1;
    drive();
    running = 1'b1;
  endtask

  always @(negedge clk) begin
    if (in_rst) begin
      chk("reset_dut1", {x1, y1, fs1, hs1, vs1, de1, r1, g1, b1}, {18'd0, 4'b0110, 16'd0});
      chk("reset_dut2", {x2, y2, fs2, hs2, vs2, de2, r2, g2, b2}, {18'd0, 4'b0110, 16'd0});
      chk("reset_dut4", {x4, y4, fs4, hs4, vs4, de4, r4, g4, b4}, {18'd0, 4'b0110, 16'd0});
    end else if (running) begin
      chk("model_dut1", {x1, y1, fs1, hs1, vs1, de1, r1, g1, b1}, model(t, 1));
      chk("model_dut2", {x2, y2, fs2, hs2, vs2, de2, r2, g2, b2}, model(t, 2));
      chk("model_dut4", {x4, y4, fs4, hs4, vs4, de4, r4, g4, b4}, model(t, 4));

      if (fs2 && t > 0) begin
        chk("fs_period", t - last_fs, FT);
        last_fs = t;
      end
      if (t == 0) chk("fs_first_xy", {fs2, x2, y2}, {1'b1, 9'd0, 9'd0});
      if (first_run) begin
        if (t >= 0 && t < FT) begin
          de_cnt += int'(de2);
          vs_cnt += int'(!vs2);
        end
        if (t >= HT && t < 2 * HT) hs_cnt += int'(!hs2);
        if (t == 2 * HT) chk("hs_low_clocks", hs_cnt, 96);
        if (t == FT) chk("de_per_frame", de_cnt, 640 * VA);
        if (t == FT) chk("vs_low_clocks", vs_cnt, 1600);
        if (t == 638) chk("x_hold_638", x2, 319);
        if (t == 639) chk("x_at_639", x2, 319);
        if (t == 799) chk("x_at_799", x2, 399);
        if (t == 800) chk("xy_line1", {x2, y2}, {9'd0, 9'd0});
        if (t == HT * 7 + 5) chk("y_at_row7", y2, 3);
        if (t == 658) chk("hs_before_fall", hs2, 1);
        if (t == 659) chk("hs_fall", hs2, 0);
        if (t == 754) chk("hs_last_low", hs2, 0);
        if (t == 755) chk("hs_rise", hs2, 1);
        if (t == 1613) chk("colour_x5_y1", {de2, r2, g2, b2}, {1'b1, 5'd5, 6'd1, 5'd5});
        if (t == FT + 900) chk("f800_active", {de2, r2}, {1'b1, 5'd31});
        if (t == FT + 1500) chk("f800_blank", {de2, r2}, {1'b0, 5'd0});
`ifdef VGA_TEST_PATTERN_EN
        if (t == 2 * FT + 813) chk("bar0_white", {de2, r2, g2, b2}, {1'b1, 16'hFFFF});
        if (t == 2 * FT + 1003) chk("bar1_yellow", {de2, r2, g2, b2}, {1'b1, 16'hFFE0});
`else
        if (t == 2 * FT + 813) chk("tm_ignored", {de2, r2, g2, b2}, {1'b1, 5'd5, 6'd0, 5'd5});
`endif
      end
    end
  end

  initial begin
    do_reset();
    while (t < 3 * FT + 3 * HT + 700) begin
      @(posedge clk);
      #1;
      t++;
      drive();
    end
    // Mid-line reset while hsync is asserted; the restart must be clean.
    first_run = 1'b0;
    last_fs = 0;
    do_reset();
    while (t < 2000) begin
      @(posedge clk);
      #1;
      t++;
      drive();
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
